// File: rtl/mem_ctrl.sv
// mem_ctrl: serialises 32-bit instruction refills and 1/2/4-byte data loads/stores onto a byte-wide RAM.
// Build option MEMCTRL_IO_GUARD_EN: I/O-region store bytes wait while io_buffer_full is high.
module mem_ctrl #(
  parameter int         ADDR_W     = 32,
  parameter logic [1:0] IO_BASE_HI = 2'b11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_needed,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic              inst_available,
  output logic [31:0]       inst,
  input  logic              branch_interception,
  input  logic              data_req,
  input  logic              data_we,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [1:0]        data_width,
  input  logic [31:0]       data_wdata,
  output logic              data_done,
  output logic [31:0]       data_rdata,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr,
  input  logic              io_buffer_full
);

  typedef enum logic [2:0] {IDLE, IFETCH, DREAD, DWRITE, DONE} state_t;

  state_t            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [1:0]        last_q, last_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       asm_q, asm_d;
  logic [ADDR_W-1:0] mem_a_q, mem_a_d;
  logic [7:0]        mem_dout_q, mem_dout_d;
  logic              mem_wr_q, mem_wr_d;
  logic [31:0]       inst_q, inst_d;
  logic              inst_avail_q, inst_avail_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              done_q, done_d;

  logic [ADDR_W-1:0] cur_addr;
  logic [2:0]        n_bytes;
  logic [1:0]        lane;
  logic              stall_accept;
  logic              stall_issue;
  logic [7:0]        wbyte [4];

  // In reads cnt counts edges since acceptance; in writes it counts bytes already issued.
  assign cur_addr = base_q + ADDR_W'(cnt_q);
  assign n_bytes  = {1'b0, last_q} + 3'd1;
  assign lane     = cnt_q[1:0] - 2'd2;

  for (genvar gi = 0; gi < 4; gi++) begin : g_wbyte
    assign wbyte[gi] = wdata_q[8*gi +: 8];
  end

`ifdef MEMCTRL_IO_GUARD_EN
  assign stall_accept = (data_addr[17:16] == IO_BASE_HI) && io_buffer_full;
  assign stall_issue  = (cur_addr[17:16] == IO_BASE_HI) && io_buffer_full;
`else
  logic unused_io;
  assign stall_accept = 1'b0;
  assign stall_issue  = 1'b0;
  assign unused_io    = io_buffer_full ^ (^IO_BASE_HI);
`endif

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_d       = last_q;
    base_d       = base_q;
    wdata_d      = wdata_q;
    asm_d        = asm_q;
    mem_a_d      = mem_a_q;
    mem_dout_d   = mem_dout_q;
    mem_wr_d     = 1'b0;
    inst_d       = inst_q;
    inst_avail_d = 1'b0;
    rdata_d      = rdata_q;
    done_d       = 1'b0;

    case (state_q)
      // DONE lasts one cycle; its closing edge selects the next request exactly like IDLE.
      IDLE, DONE: begin
        state_d = IDLE;
        cnt_d   = 3'd0;
        if (data_req) begin
          base_d  = data_addr;
          last_d  = data_width;
          wdata_d = data_wdata;
          asm_d   = '0;
          cnt_d   = 3'd1;
          if (data_we) begin
            state_d = DWRITE;
            if (stall_accept) begin
              cnt_d = 3'd0;
            end else begin
              mem_a_d    = data_addr;
              mem_dout_d = data_wdata[7:0];
              mem_wr_d   = 1'b1;
            end
          end else begin
            state_d = DREAD;
            mem_a_d = data_addr;
          end
        end else if (inst_needed && !branch_interception) begin
          state_d = IFETCH;
          base_d  = inst_addr;
          last_d  = 2'd3;
          asm_d   = '0;
          cnt_d   = 3'd1;
          mem_a_d = inst_addr;
        end
      end

      IFETCH, DREAD: begin
        if (state_q == IFETCH && branch_interception) begin
          state_d = IDLE;
          cnt_d   = 3'd0;
        end else begin
          if (cnt_q >= 3'd2) begin
            asm_d[{lane, 3'b000} +: 8] = mem_din;
          end
          if (cnt_q < n_bytes) begin
            mem_a_d = cur_addr;
          end
          if (cnt_q == n_bytes + 3'd1) begin
            state_d = DONE;
            cnt_d   = 3'd0;
            if (state_q == IFETCH) begin
              inst_d       = asm_d;
              inst_avail_d = 1'b1;
            end else begin
              rdata_d = asm_d;
              done_d  = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end

      DWRITE: begin
        if (cnt_q == n_bytes) begin
          state_d = DONE;
          cnt_d   = 3'd0;
          done_d  = 1'b1;
        end else if (!stall_issue) begin
          mem_a_d    = cur_addr;
          mem_dout_d = wbyte[cnt_q[1:0]];
          mem_wr_d   = 1'b1;
          cnt_d      = cnt_q + 3'd1;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= 3'd0;
      last_q       <= 2'd0;
      base_q       <= '0;
      wdata_q      <= '0;
      asm_q        <= '0;
      mem_a_q      <= '0;
      mem_dout_q   <= '0;
      mem_wr_q     <= 1'b0;
      inst_q       <= '0;
      inst_avail_q <= 1'b0;
      rdata_q      <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_q       <= last_d;
      base_q       <= base_d;
      wdata_q      <= wdata_d;
      asm_q        <= asm_d;
      mem_a_q      <= mem_a_d;
      mem_dout_q   <= mem_dout_d;
      mem_wr_q     <= mem_wr_d;
      inst_q       <= inst_d;
      inst_avail_q <= inst_avail_d;
      rdata_q      <= rdata_d;
      done_q       <= done_d;
    end
  end

  assign inst_available = inst_avail_q;
  assign inst           = inst_q;
  assign data_done      = done_q;
  assign data_rdata     = rdata_q;
  assign mem_dout       = mem_dout_q;
  assign mem_a          = mem_a_q;
  assign mem_wr         = mem_wr_q;

endmodule
